// File: rtl/thermal_pkg.sv
// Shared definitions for the thermal covert channel: FSM states, timing and
// preamble defaults, shared by the transmitter and the receiver.
package thermal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_GUARD = 3'd4
  } state_e;

  localparam int unsigned DEF_BIT_PERIOD   = 33554432;
  localparam int unsigned DEF_GUARD_PERIOD = 67108864;
  localparam int unsigned DEF_PRE_LEN      = 4;
  localparam logic [DEF_PRE_LEN-1:0] DEF_PREAMBLE = 4'b1010;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/thermal_heater_bank.sv
// Bank of heater flops: toggles every clock while enabled, held at zero otherwise.
module thermal_heater_bank #(
  parameter int unsigned HEATER_WIDTH = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic probe
);

  (* keep = "true" *) logic [HEATER_WIDTH-1:0] bank_q;

  // NOTE: the bank is plain flops, not a RAM, so it takes the async clear like any
  // other register; a reset must stop the heating at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
    end else if (enable) begin
      // NOTE: sequential state is always assigned with <= so every flop samples
      // pre-edge values regardless of statement order.
      bank_q <= ~bank_q;
    end else begin
      bank_q <= '0;
    end
  end

  assign probe = bank_q[0];

endmodule

// File: rtl/thermal_channel_tx.sv
// Transmit end of the thermal covert channel: sends preamble, payload and even
// parity as on-off-keyed heater symbols, then enforces a cool-down guard.
module thermal_channel_tx
  import thermal_pkg::*;
#(
  parameter int unsigned BIT_PERIOD   = DEF_BIT_PERIOD,
  parameter int unsigned GUARD_PERIOD = DEF_GUARD_PERIOD,
  parameter int unsigned HEATER_WIDTH = 1024,
  parameter int unsigned MSG_WIDTH    = 8,
  parameter int unsigned PRE_LEN      = DEF_PRE_LEN,
  parameter logic [PRE_LEN-1:0] PREAMBLE = DEF_PREAMBLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MSG_WIDTH-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 heat_on,
  output logic [3:0]           bit_idx,
  output logic                 heat_probe
);

  localparam int unsigned CNT_W     = $clog2(max_u(BIT_PERIOD, GUARD_PERIOD));
  localparam int unsigned FRAME_LEN = PRE_LEN + MSG_WIDTH + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 heat_on_q, heat_on_d;
  logic                 sym_end;
  logic                 guard_end;

  assign sym_end   = (cnt_q == CNT_W'(BIT_PERIOD - 1));
  assign guard_end = (cnt_q == CNT_W'(GUARD_PERIOD - 1));

  // NOTE: every signal gets a default at the top of always_comb so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          // Whole frame is loaded at once; the MSB is always the symbol on air.
          state_d = ST_PRE;
          idx_d   = '0;
          shreg_d = {PREAMBLE, data, ^data};
        end
      end
      ST_PRE: begin
        if (sym_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          if (idx_q == 4'(PRE_LEN - 1)) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (sym_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          if (idx_q == 4'(MSG_WIDTH - 1)) begin
            state_d = ST_PAR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (sym_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_end) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    heat_on_d = ((state_d == ST_PRE) || (state_d == ST_DATA) || (state_d == ST_PAR))
                ? shreg_d[FRAME_LEN-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      heat_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      heat_on_q <= heat_on_d;
    end
  end

  thermal_heater_bank #(
    .HEATER_WIDTH(HEATER_WIDTH)
  ) u_heater_bank (
    .clk   (clk),
    .rst   (rst),
    .enable(heat_on_q),
    .probe (heat_probe)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign heat_on = heat_on_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_thermal_channel_tx.sv
// Directed bench for thermal_channel_tx with short symbol and guard periods.
module tb_thermal_channel_tx;

  localparam int BP   = 4;
  localparam int GP   = 8;
  localparam int NCAP = 62;
  localparam int FRAME_CYC = 13 * BP + GP;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       busy, done, heat_on, heat_probe;
  logic [3:0] bit_idx;

  int total = 0;
  int bad   = 0;

  logic       cap_busy  [NCAP];
  logic       cap_done  [NCAP];
  logic       cap_heat  [NCAP];
  logic       cap_probe [NCAP];
  logic [3:0] cap_idx   [NCAP];

  thermal_channel_tx #(
    .BIT_PERIOD  (BP),
    .GUARD_PERIOD(GP),
    .HEATER_WIDTH(16),
    .MSG_WIDTH   (8),
    .PRE_LEN     (4),
    .PREAMBLE    (4'b1010)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .heat_on   (heat_on),
    .bit_idx   (bit_idx),
    .heat_probe(heat_probe)
  );

  always #5 clk = ~clk;

  // Expected symbol value at cycle j after the accepting edge (j=0 is the first busy cycle).
  function automatic logic exp_heat(input logic [7:0] d, input int j);
    logic [12:0] f;
    int sym;
    sym = j / BP;
    if (sym >= 13) return 1'b0;
    f = {4'b1010, d, ^d};
    f = f << sym;
    return f[12];
  endfunction

  function automatic logic [3:0] exp_idx(input int j);
    int sym;
    sym = j / BP;
    if (sym < 4)  return 4'(sym);
    if (sym < 12) return 4'(sym - 4);
    return 4'd0;
  endfunction

  // mode 0: single start pulse; 1: start held high; 2: extra starts with data=FF mid-frame
  task automatic send_and_capture(input logic [7:0] d, input int mode);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    for (int j = 0; j < NCAP; j++) begin
      @(negedge clk);
      cap_busy[j]  = busy;
      cap_done[j]  = done;
      cap_heat[j]  = heat_on;
      cap_probe[j] = heat_probe;
      cap_idx[j]   = bit_idx;
      if (mode != 1) start = 1'b0;
      if (mode == 2 && (j == 4 || j == 19)) begin
        start = 1'b1;
        data  = 8'hFF;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    #12;
    total++;
    if ({busy, done, heat_on, heat_probe, bit_idx} !== 8'h00) begin
      bad++;
      $display("FAIL reset_values got=%b want=00000000", {busy, done, heat_on, heat_probe, bit_idx});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, heat_on, heat_probe, bit_idx} !== 8'h00) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d got=%b want=00000000", i,
                 {busy, done, heat_on, heat_probe, bit_idx});
      end
    end
  endtask

  task automatic test_frame_a5();
    int nbusy, ndone;
    logic prev_heat, exp_probe;
    send_and_capture(8'hA5, 0);
    nbusy = 0;
    ndone = 0;
    prev_heat = 1'b0;
    exp_probe = 1'b0;
    for (int j = 0; j < NCAP; j++) begin
      exp_probe = prev_heat ? ~exp_probe : 1'b0;
      if (cap_busy[j] === 1'b1) nbusy++;
      if (cap_done[j] === 1'b1) ndone++;
      total++;
      if (cap_busy[j] !== (j < FRAME_CYC)) begin
        bad++;
        $display("FAIL a5_busy j=%0d got=%b want=%b", j, cap_busy[j], (j < FRAME_CYC));
      end
      total++;
      if (cap_done[j] !== (j == FRAME_CYC)) begin
        bad++;
        $display("FAIL a5_done j=%0d got=%b want=%b", j, cap_done[j], (j == FRAME_CYC));
      end
      total++;
      if (cap_heat[j] !== exp_heat(8'hA5, j)) begin
        bad++;
        $display("FAIL a5_heat j=%0d got=%b want=%b", j, cap_heat[j], exp_heat(8'hA5, j));
      end
      total++;
      if (cap_idx[j] !== exp_idx(j)) begin
        bad++;
        $display("FAIL a5_bit_idx j=%0d got=%0d want=%0d", j, cap_idx[j], exp_idx(j));
      end
      total++;
      if (cap_probe[j] !== exp_probe) begin
        bad++;
        $display("FAIL a5_probe j=%0d got=%b want=%b", j, cap_probe[j], exp_probe);
      end
      prev_heat = exp_heat(8'hA5, j);
    end
    total++;
    if (nbusy != FRAME_CYC) begin
      bad++;
      $display("FAIL a5_busy_len got=%0d want=%0d", nbusy, FRAME_CYC);
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL a5_done_count got=%0d want=1", ndone);
    end
  endtask

  task automatic test_parity_probe();
    send_and_capture(8'h01, 0);
    for (int j = 48; j < 52; j++) begin
      total++;
      if (cap_heat[j] !== 1'b1) begin
        bad++;
        $display("FAIL par_heat j=%0d got=%b want=1", j, cap_heat[j]);
      end
    end
    for (int j = 45; j < 53; j++) begin
      total++;
      if (cap_probe[j] !== ~cap_probe[j-1]) begin
        bad++;
        $display("FAIL probe_toggle j=%0d got=%b want=%b", j, cap_probe[j], ~cap_probe[j-1]);
      end
    end
    for (int j = 53; j < NCAP; j++) begin
      total++;
      if (cap_probe[j] !== 1'b0 || cap_heat[j] !== 1'b0) begin
        bad++;
        $display("FAIL guard_quiet j=%0d got=%b%b want=00", j, cap_heat[j], cap_probe[j]);
      end
    end
  endtask

  task automatic test_ignore_start();
    send_and_capture(8'hA5, 2);
    for (int j = 0; j < NCAP; j++) begin
      total++;
      if (cap_heat[j] !== exp_heat(8'hA5, j) || cap_busy[j] !== (j < FRAME_CYC)) begin
        bad++;
        $display("FAIL ignore_start j=%0d got=heat%b busy%b want=heat%b busy%b", j,
                 cap_heat[j], cap_busy[j], exp_heat(8'hA5, j), (j < FRAME_CYC));
      end
    end
    data = 8'hA5;
  endtask

  task automatic test_back_to_back();
    send_and_capture(8'hA5, 1);
    total++;
    if (cap_done[FRAME_CYC] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done got=%b want=1", cap_done[FRAME_CYC]);
    end
    total++;
    if ({cap_busy[FRAME_CYC+1], cap_heat[FRAME_CYC+1], cap_idx[FRAME_CYC+1]} !== 6'b110000) begin
      bad++;
      $display("FAIL b2b_restart got=%b want=110000",
               {cap_busy[FRAME_CYC+1], cap_heat[FRAME_CYC+1], cap_idx[FRAME_CYC+1]});
    end
    for (int j = 0; j < FRAME_CYC; j++) begin
      total++;
      if (cap_heat[j] !== exp_heat(8'hA5, j) || cap_done[j] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first j=%0d got=heat%b done%b want=heat%b done0", j,
                 cap_heat[j], cap_done[j], exp_heat(8'hA5, j));
      end
    end
    repeat (FRAME_CYC + 10) @(negedge clk);
    total++;
    if ({busy, done, heat_on} !== 3'b000) begin
      bad++;
      $display("FAIL b2b_drain got=%b want=000", {busy, done, heat_on});
    end
  endtask

  task automatic test_async_reset();
    int ndone;
    @(negedge clk);
    start = 1'b1;
    data  = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    total++;
    if ({heat_on, heat_probe} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset_heat got=%b want=11", {heat_on, heat_probe});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, heat_on, heat_probe} !== 3'b000) begin
      bad++;
      $display("FAIL async_clear got=%b want=000", {busy, heat_on, heat_probe});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < FRAME_CYC + 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_busy cyc=%0d got=%b want=0", i, busy);
      end
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL post_reset_done got=%0d want=0", ndone);
    end
    total++;
    if ({heat_on, heat_probe, bit_idx} !== 6'b000000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=000000", {heat_on, heat_probe, bit_idx});
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    repeat (5) @(negedge clk);
    test_parity_probe();
    repeat (5) @(negedge clk);
    test_ignore_start();
    repeat (5) @(negedge clk);
    test_back_to_back();
    repeat (5) @(negedge clk);
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thermal_channel_tx.md
Name: thermal_channel_tx

Overview:
Transmit end of the temporal thermal covert channel. It accepts one data byte and sends it as an on-off-keyed thermal frame. For each symbol, a bank of heater flops either toggles every clock (logic 1, heat) or is held quiet (logic 0, cool). The ring-oscillator counter block on the receiving die measures the resulting frequency drift. The block sits beside the receiver in the same fabric and is driven by a host or by switch inputs.

Parameters:
BIT_PERIOD, 33554432, clock cycles per symbol; minimum 2.
GUARD_PERIOD, 67108864, clock cycles of forced cool-down after each frame; minimum 1.
HEATER_WIDTH, 1024, number of toggling heater flops.
MSG_WIDTH, 8, payload bits per frame.
PRE_LEN, 4, preamble length in symbols.
PREAMBLE, 4'b1010, preamble pattern, sent MSB first.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request to send; sampled only in IDLE
data  in  MSG_WIDTH  payload; latched on the accepted start
busy  out  1  frame in progress, including guard time
done  out  1  one-cycle pulse at frame completion
heat_on  out  1  current symbol value; heater bank enable
bit_idx  out  4  index of the current symbol within its phase
heat_probe  out  1  heater bank bit 0; keeps the bank from being optimised away

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; busy, done, heat_on, bit_idx, heat_probe all 0; heater bank all 0; symbol counter 0.
- Reset asserted mid-frame: heat_on and the heater bank clear immediately (asynchronously). No done pulse is produced, and the frame is lost.
- FSM states: IDLE, PRE, DATA, PAR, GUARD.
- IDLE to PRE:
  - Taken on clock edge k when start=1.
  - On that edge, data is latched into shift register sreg and parity is computed as par = ^data (even parity).
  - From cycle k+1: busy=1, heat_on=PREAMBLE[PRE_LEN-1], bit_idx=0.
- Symbol timing: a counter runs 0..BIT_PERIOD-1. Every symbol lasts exactly BIT_PERIOD cycles. heat_on changes only at symbol boundaries.
- PRE: sends PREAMBLE MSB first; bit_idx runs 0..PRE_LEN-1. After the last symbol, go to DATA.
- DATA: sends sreg MSB first; bit_idx runs 0..MSG_WIDTH-1. After the last symbol, go to PAR.
- PAR: one symbol with heat_on=par; bit_idx=0. Then go to GUARD.
- GUARD: heat_on=0 for exactly GUARD_PERIOD cycles; bit_idx=0.
- Return to IDLE:
  - On the edge ending GUARD: state becomes IDLE, busy=0, done=1 for exactly one cycle.
  - A start sampled on that done cycle is accepted normally, giving back-to-back frames.
- Total frame length: busy is high for exactly (PRE_LEN+MSG_WIDTH+1)*BIT_PERIOD + GUARD_PERIOD cycles.
- start while busy: ignored. Any data changes while busy are ignored.
- heat_on is a registered output, driven directly from a flop.
- Heater bank:
  - When enable=0: bank <= 0 every cycle.
  - When enable=1: bank <= ~bank every cycle.
  - heat_probe = bank[0], so it toggles every cycle while heat_on=1 and is 0 otherwise. The first toggle follows heat_on by one cycle.
- Counters:
  - Symbol counter width is $clog2(max(BIT_PERIOD, GUARD_PERIOD)).
  - The counter wraps to 0 at each symbol boundary. It is never compared beyond its terminal value.

Decomposition:
- Shared package thermal_pkg: state enum (IDLE, PRE, DATA, PAR, GUARD), the PREAMBLE constant, and the default BIT_PERIOD/GUARD_PERIOD constants. The receiver block uses the same timing constants.
- Sub-module thermal_heater_bank:
  - Ports: clk, rst, enable, probe.
  - Parameter: HEATER_WIDTH.
  - Carries synthesis keep attributes on the bank.

Test Plan (BIT_PERIOD=4, GUARD_PERIOD=8):
- Reset then idle 20 cycles -> busy=0, done=0, heat_on=0, heat_probe=0 throughout.
- start=1 for one cycle with data=8'hA5:
  - busy high for exactly 60 cycles.
  - heat_on, sampled each 4-cycle symbol, reads 1,0,1,0 | 1,0,1,0,0,1,0,1 | 0, then 0 for 8 cycles.
  - done pulses once, on the cycle busy falls.
- data=8'h01 -> parity symbol heat_on=1. While heat_on=1, heat_probe toggles every cycle; after GUARD begins, heat_probe=0.
- start pulsed at cycles 5 and 20 of a frame with data changed to 8'hFF -> ignored; the transmitted payload stays 8'hA5.
- start held high continuously -> second frame begins on the done cycle; the next cycle has busy=1 and heat_on=1 (first preamble bit).
- rst asserted asynchronously mid-DATA (between clock edges) -> heat_on and heat_probe drop before the next edge. After release: IDLE, no done pulse.
